// File: rtl/i2s_pkg.sv
// Shared types and constants for the AXI-Stream to I2S serializer.
// Holds the FSM encoding, sample field position and parameter legality rule.
package i2s_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int unsigned AUD_LSB  = 4;
   localparam logic        CH_LEFT  = 1'b0;
   localparam logic        CH_RIGHT = 1'b1;

   function automatic bit params_ok(input int unsigned sample_w,
                                    input int unsigned slot_w,
                                    input int unsigned sclk_div);
      return (sample_w >= 1) && (slot_w >= sample_w + 1) &&
             (sclk_div >= 2) && (sample_w + AUD_LSB <= 32);
   endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// I2S bit-clock divider: sclk toggles every SCLK_DIV aclk cycles while running.
// Rise/fall strobes mark the aclk cycle whose edge moves sclk.
module i2s_sclk_gen #(
   parameter int unsigned SCLK_DIV = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_run,
   output logic o_sclk,
   output logic o_rise,
   output logic o_fall
);

   localparam int unsigned DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

   logic [DW-1:0] r_div_cnt;
   logic          r_sclk;
   logic          w_tc;

   assign w_tc = i_run && (r_div_cnt == DW'(SCLK_DIV - 1));

   // Holding the divider cleared while stopped makes the first rise land
   // exactly SCLK_DIV cycles after run goes high.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || !i_run) begin
         r_div_cnt <= '0;
         r_sclk    <= 1'b0;
      end else if (w_tc) begin
         r_div_cnt <= '0;
         r_sclk    <= ~r_sclk;
      end else begin
         r_div_cnt <= r_div_cnt + DW'(1);
      end
   end

   assign o_sclk = r_sclk;
   assign o_rise = w_tc && !r_sclk;
   assign o_fall = w_tc &&  r_sclk;

endmodule

// File: rtl/i2s_stream_serializer.sv
// AXI-Stream (L/R sample pairs) to I2S transmitter in the aclk domain.
// A two-entry pair buffer feeds frame registers that are serialized MSB first.
module i2s_stream_serializer
   import i2s_pkg::*;
#(
   parameter int unsigned SAMPLE_W = 24,
   parameter int unsigned SLOT_W   = 32,
   parameter int unsigned SCLK_DIV = 8
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        en_i,
   input  logic [31:0] s_axis_tdata,
   input  logic [2:0]  s_axis_tid,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic        sclk_o,
   output logic        lrclk_o,
   output logic        sdata_o,
   output logic        underrun_o,
   output logic        sync_err_o
);

   if (!params_ok(SAMPLE_W, SLOT_W, SCLK_DIV)) begin : g_param_check
      $error("i2s_stream_serializer: illegal SAMPLE_W/SLOT_W/SCLK_DIV combination");
   end

   localparam int unsigned BCW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

   state_t              r_state;
   logic [SAMPLE_W-1:0] r_left_q, r_right_q;
   logic [SAMPLE_W-1:0] r_left_sh, r_right_sh;
   logic                r_left_v, r_right_v;
   logic [BCW-1:0]      r_bit_cnt;
   logic                r_lrclk, r_sdata, r_underrun, r_sync_err;

   logic                w_sclk, w_rise_unused, w_fall, w_run;
   logic                w_pair, w_tready, w_hs;
   logic                w_slot_end, w_frame_end, w_entry, w_load;
   logic [SAMPLE_W-1:0] w_audio, w_word;
   logic [BCW-1:0]      w_next_k;
   logic                w_next_lr, w_next_bit;
   logic [34:0]         w_in_unused;

   assign w_run = (r_state == RUN);

   i2s_sclk_gen #(
      .SCLK_DIV (SCLK_DIV)
   ) u_sclk_gen (
      .i_clk   (aclk),
      .i_rst_n (aresetn),
      .i_run   (w_run),
      .o_sclk  (w_sclk),
      .o_rise  (w_rise_unused),
      .o_fall  (w_fall)
   );

   assign w_in_unused = {s_axis_tdata, s_axis_tid};
   assign w_audio     = s_axis_tdata[SAMPLE_W+AUD_LSB-1:AUD_LSB];

   assign w_pair      = r_left_v && r_right_v;
   assign w_tready    = aresetn && en_i && !w_pair;
   assign w_hs        = s_axis_tvalid && w_tready;

   assign w_slot_end  = w_fall && (r_bit_cnt == BCW'(SLOT_W - 1));
   assign w_frame_end = w_slot_end && r_lrclk;
   assign w_entry     = (r_state == IDLE) && en_i;
   assign w_load      = w_entry || (w_frame_end && en_i);

   // Bit for the slot position reached at this fall: k=0 is the I2S delay
   // bit, k=1..SAMPLE_W carry the sample MSB first, the rest pad with zero.
   always_comb begin
      w_next_k   = (r_bit_cnt == BCW'(SLOT_W - 1)) ? '0 : r_bit_cnt + BCW'(1);
      w_next_lr  = w_slot_end ? ~r_lrclk : r_lrclk;
      w_word     = w_next_lr ? r_right_sh : r_left_sh;
      w_next_bit = 1'b0;
      for (int unsigned i = 0; i < SAMPLE_W; i++) begin
         if (w_next_k == BCW'(SAMPLE_W - i)) w_next_bit = w_word[i];
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state    <= IDLE;
         r_left_q   <= '0;
         r_right_q  <= '0;
         r_left_sh  <= '0;
         r_right_sh <= '0;
         r_left_v   <= 1'b0;
         r_right_v  <= 1'b0;
         r_bit_cnt  <= '0;
         r_lrclk    <= 1'b0;
         r_sdata    <= 1'b0;
         r_underrun <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         r_underrun <= 1'b0;
         r_sync_err <= 1'b0;

         if (w_hs) begin
            if (s_axis_tid[0] == CH_LEFT) begin
               r_left_q <= w_audio;
               r_left_v <= 1'b1;
               if (r_left_v) r_sync_err <= 1'b1;
            end else if (r_left_v) begin
               r_right_q <= w_audio;
               r_right_v <= 1'b1;
            end else begin
               r_sync_err <= 1'b1;
            end
         end

         // A full buffer forces tready low, so a load never races a handshake.
         if (w_load) begin
            if (w_pair) begin
               r_left_sh  <= r_left_q;
               r_right_sh <= r_right_q;
               r_left_v   <= 1'b0;
               r_right_v  <= 1'b0;
            end else begin
               r_left_sh  <= '0;
               r_right_sh <= '0;
               r_underrun <= 1'b1;
            end
         end

         unique case (r_state)
            IDLE: begin
               if (en_i) begin
                  r_state   <= RUN;
                  r_bit_cnt <= '0;
                  r_lrclk   <= 1'b0;
                  r_sdata   <= 1'b0;
               end
            end
            RUN: begin
               if (w_fall) begin
                  if (w_frame_end && !en_i) begin
                     r_state   <= IDLE;
                     r_bit_cnt <= '0;
                     r_lrclk   <= 1'b0;
                     r_sdata   <= 1'b0;
                  end else begin
                     r_bit_cnt <= w_next_k;
                     r_lrclk   <= w_next_lr;
                     r_sdata   <= w_next_bit;
                  end
               end
            end
         endcase
      end
   end

   assign s_axis_tready = w_tready;
   assign sclk_o        = w_sclk;
   assign lrclk_o       = r_lrclk;
   assign sdata_o       = r_sdata;
   assign underrun_o    = r_underrun;
   assign sync_err_o    = r_sync_err;

endmodule

// File: tb/tb_i2s_stream_serializer.sv
// Scoreboard bench for i2s_stream_serializer: stimulus queues expected slot words,
// a monitor rebuilds each 32-bit slot from sdata at sclk rises and compares.
module tb_i2s_stream_serializer;

   localparam int unsigned SAMPLE_W = 24;
   localparam int unsigned SLOT_W   = 32;
   localparam int unsigned SCLK_DIV = 8;
   localparam int          FRAME    = 2 * SLOT_W * 2 * SCLK_DIV;

   logic        aclk    = 1'b0;
   logic        aresetn = 1'b0;
   logic        en_i    = 1'b0;
   logic [31:0] tdata   = '0;
   logic [2:0]  tid     = '0;
   logic        tvalid  = 1'b0;
   logic        tready, sclk_o, lrclk_o, sdata_o, underrun_o, sync_err_o;

   always #5 aclk = ~aclk;

   i2s_stream_serializer #(
      .SAMPLE_W (SAMPLE_W),
      .SLOT_W   (SLOT_W),
      .SCLK_DIV (SCLK_DIV)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .en_i          (en_i),
      .s_axis_tdata  (tdata),
      .s_axis_tid    (tid),
      .s_axis_tvalid (tvalid),
      .s_axis_tready (tready),
      .sclk_o        (sclk_o),
      .lrclk_o       (lrclk_o),
      .sdata_o       (sdata_o),
      .underrun_o    (underrun_o),
      .sync_err_o    (sync_err_o)
   );

   int checks = 0, failures = 0;
   int cyc = 0, t_entry = 0;
   int ur_cnt = 0, se_cnt = 0, rise_cnt = 0;
   logic [32:0] exp_q[$];

   function automatic logic [32:0] slot_word(input logic lr, input logic [23:0] s);
      return {lr, 1'b0, s, 7'b0};
   endfunction

   task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
      exp_q.push_back(slot_word(1'b0, l));
      exp_q.push_back(slot_word(1'b1, r));
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic wait_to(input int n);
      while (cyc - t_entry < n) @(posedge aclk);
      #1;
   endtask

   // Presents one word and waits for its handshake; tvalid is left high.
   task automatic send(input logic [31:0] d, input logic [2:0] id);
      bit ok = 1'b0;
      tdata  = d;
      tid    = id;
      tvalid = 1'b1;
      for (int n = 0; n < 3 * FRAME && !ok; n++) begin
         #1;
         if (tready) ok = 1'b1;
         @(posedge aclk);
      end
      #1;
      chk("send_accept", 32'(ok), 32'd1);
   endtask

   initial forever begin
      @(posedge aclk);
      cyc++;
   end

   // Monitor: slot assembly, stability of sdata/lrclk while sclk is high.
   initial begin
      int          bits = 0, slot_n = 0;
      logic        unstable = 1'b0, lr_slot = 1'b0;
      logic        p_sclk = 1'b0, p_sd = 1'b0, p_lr = 1'b0;
      logic [31:0] word = '0;
      logic [32:0] e;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            bits     = 0;
            unstable = 1'b0;
         end else begin
            if (underrun_o) ur_cnt++;
            if (sync_err_o) se_cnt++;
            if (sclk_o && (sdata_o !== p_sd || lrclk_o !== p_lr)) unstable = 1'b1;
            if (sclk_o && !p_sclk) begin
               rise_cnt++;
               if (bits == 0) lr_slot = lrclk_o;
               else if (lrclk_o !== lr_slot) unstable = 1'b1;
               word = {word[30:0], sdata_o};
               bits++;
               if (bits == SLOT_W) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL slot%0d unexpected lr=%0b data=%h", slot_n, lr_slot, word);
                  end else begin
                     e = exp_q.pop_front();
                     if ({lr_slot, word} !== e || unstable) begin
                        failures++;
                        $display("FAIL slot%0d got lr=%0b data=%h unstable=%0b exp lr=%0b data=%h",
                                 slot_n, lr_slot, word, unstable, e[32], e[31:0]);
                     end
                  end
                  slot_n++;
                  bits     = 0;
                  unstable = 1'b0;
               end
            end
         end
         p_sclk = sclk_o;
         p_sd   = sdata_o;
         p_lr   = lrclk_o;
      end
   end

   initial begin
      int ur0, se0, r0;
      en_i = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_sclk", 32'(sclk_o), 0);
      chk("rst_lrclk", 32'(lrclk_o), 0);
      chk("rst_sdata", 32'(sdata_o), 0);
      chk("rst_tready", 32'(tready), 0);
      chk("rst_underrun", 32'(underrun_o), 0);
      chk("rst_sync_err", 32'(sync_err_o), 0);

      // Basic pair; first frame underruns, tid[2:1] and tdata pad bits ignored.
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      t_entry = cyc;
      chk("entry_underrun", 32'(underrun_o), 1);
      chk("entry_lrclk", 32'(lrclk_o), 0);
      push_frame(24'h0, 24'h0);
      push_frame(24'h0ABCDE, 24'h123456);
      send(32'h00ABCDE0, 3'b000);
      send(32'hF123456A, 3'b111);
      tvalid = 1'b0;
      push_frame(24'h0, 24'h0);
      wait_to(2050);
      chk("underrun_count_3frames", 32'(ur_cnt), 2);

      // Sync errors: orphan right is dropped, second left overwrites.
      se0 = se_cnt;
      send(32'h01111110, 3'b001);
      send(32'h02222220, 3'b000);
      send(32'h03333330, 3'b000);
      send(32'h04444440, 3'b001);
      tvalid = 1'b0;
      push_frame(24'h333333, 24'h444444);
      wait_to(2100);
      chk("sync_err_count", 32'(se_cnt - se0), 2);

      // Backpressure: tvalid held high across eight pairs.
      wait_to(3 * FRAME);
      for (int i = 0; i < 8; i++) begin
         logic [23:0] l, r;
         l = 24'hA00000 + 24'(i) * 24'h010101;
         r = 24'h500000 + 24'(i) * 24'h0F0F0F;
         push_frame(l, r);
         send({4'h0, l, 4'h0}, 3'b000);
         send({4'h0, r, 4'h0}, 3'b001);
         chk("tready_full", 32'(tready), 0);
         if (i == 0) begin
            tdata = {4'h0, 24'hA10101, 4'h0};
            tid   = 3'b000;
            wait_to(4 * FRAME - 1);
            chk("tready_before_load", 32'(tready), 0);
            wait_to(4 * FRAME);
            chk("tready_after_load", 32'(tready), 1);
         end
      end

      // Disable mid-frame with a left word left in the buffer.
      push_frame(24'h6789AB, 24'hCDEF01);
      send(32'h06789AB0, 3'b000);
      send(32'h0CDEF010, 3'b001);
      send(32'h0D0D0D00, 3'b000);
      tvalid = 1'b0;
      wait_to(12 * FRAME + 82);
      ur0  = ur_cnt;
      en_i = 1'b0;
      #1;
      chk("disable_tready", 32'(tready), 0);
      wait_to(13 * FRAME - 1);
      chk("disable_still_running", 32'(lrclk_o), 1);
      wait_to(13 * FRAME);
      chk("idle_sclk", 32'(sclk_o), 0);
      chk("idle_lrclk", 32'(lrclk_o), 0);
      chk("idle_sdata", 32'(sdata_o), 0);
      r0 = rise_cnt;
      wait_to(13 * FRAME + 90);
      chk("idle_no_rise", 32'(rise_cnt - r0), 0);
      chk("idle_no_underrun", 32'(ur_cnt - ur0), 0);

      // Re-enable: retained left pairs with a fresh right word.
      en_i = 1'b1;
      @(posedge aclk);
      #1;
      t_entry = cyc;
      chk("reentry_underrun", 32'(underrun_o), 1);
      push_frame(24'h0, 24'h0);
      push_frame(24'hD0D0D0, 24'hE0E0E0);
      se0 = se_cnt;
      send(32'h0E0E0E00, 3'b001);
      tvalid = 1'b0;
      chk("retained_left_no_sync_err", 32'(se_cnt - se0), 0);
      send(32'h0F0F0F00, 3'b000);
      send(32'h01212120, 3'b001);
      tvalid = 1'b0;

      // Reset at bit 10 of the left slot with a full buffer.
      wait_to(FRAME + 165);
      aresetn = 1'b0;
      exp_q.delete();
      @(posedge aclk);
      #1;
      chk("midrst_sclk", 32'(sclk_o), 0);
      chk("midrst_lrclk", 32'(lrclk_o), 0);
      chk("midrst_sdata", 32'(sdata_o), 0);
      chk("midrst_tready", 32'(tready), 0);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      t_entry = cyc;
      ur0 = ur_cnt;
      chk("postrst_underrun", 32'(underrun_o), 1);
      push_frame(24'h0, 24'h0);
      push_frame(24'h0, 24'h0);
      wait_to(FRAME + 6);
      en_i = 1'b0;
      wait_to(2 * FRAME + 12);
      chk("postrst_underrun_count", 32'(ur_cnt - ur0), 2);
      chk("final_lrclk", 32'(lrclk_o), 0);
      chk("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
